// File: rtl/fp_classify.sv
// Multi-lane IEEE-754 style float classifier with a one-deep output register,
// sticky class flags and a saturating NaN-lane counter.
module fp_classify #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [LANES*7-1:0]      class_o,
    output logic [3:0]              sticky_o,
    output logic [CNT_W-1:0]        nan_cnt_o
);

    localparam int MAN_W = DATA_W - 1 - EXP_W;
    // Sum width must hold a full counter plus a whole beat of NaN lanes.
    localparam int SUM_W = CNT_W + $clog2(LANES + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    if (MAN_W < 2) begin : g_bad_params
        $error("fp_classify: mantissa width must be at least 2");
    end

    typedef struct packed {
        logic sign;
        logic snan;
        logic qnan;
        logic inf;
        logic zero;
        logic sub;
        logic normal;
    } cls_t;

    function automatic cls_t classify(input logic [DATA_W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        cls_t             c;
        e      = x[DATA_W-2 -: EXP_W];
        m      = x[MAN_W-1:0];
        c      = '0;
        c.sign = x[DATA_W-1];
        if (&e) begin
            if (m == '0)          c.inf  = 1'b1;
            else if (m[MAN_W-1])  c.qnan = 1'b1;
            else                  c.snan = 1'b1;
        end else if (e == '0) begin
            if (m == '0)          c.zero = 1'b1;
            else                  c.sub  = 1'b1;
        end else begin
            c.normal = 1'b1;
        end
        return c;
    endfunction

    cls_t               lane_c [LANES];
    logic [LANES*7-1:0] beat_cls;
    logic [3:0]         beat_sticky;
    logic [SUM_W-1:0]   beat_nans;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_c[k]           = classify(data_i[k*DATA_W +: DATA_W]);
        assign beat_cls[k*7 +: 7]  = lane_c[k];
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        beat_sticky = '0;
        beat_nans   = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sticky = beat_sticky | {lane_c[k].snan | lane_c[k].qnan, lane_c[k].inf,
                                         lane_c[k].zero, lane_c[k].sub};
            beat_nans   = beat_nans + SUM_W'(lane_c[k].snan | lane_c[k].qnan);
        end
    end

    logic               valid_q,   valid_d;
    logic [LANES*7-1:0] class_q,   class_d;
    logic [3:0]         sticky_q,  sticky_d;
    logic [CNT_W-1:0]   nan_cnt_q, nan_cnt_d;
    logic               accept;
    logic [3:0]         sticky_base;
    logic [CNT_W-1:0]   cnt_base;
    logic [SUM_W-1:0]   cnt_sum;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        valid_d     = valid_q;
        class_d     = class_q;
        // Clear applies first so a same-cycle accept leaves only its own contribution.
        sticky_base = clear_i ? 4'b0 : sticky_q;
        cnt_base    = clear_i ? '0 : nan_cnt_q;
        cnt_sum     = SUM_W'(cnt_base) + beat_nans;
        sticky_d    = sticky_base;
        nan_cnt_d   = cnt_base;
        if (accept) begin
            valid_d   = 1'b1;
            class_d   = beat_cls;
            sticky_d  = sticky_base | beat_sticky;
            nan_cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the output class register is reset too, since its reset value is observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            class_q   <= '0;
            sticky_q  <= 4'b0;
            nan_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            class_q   <= class_d;
            sticky_q  <= sticky_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign class_o   = class_q;
    assign sticky_o  = sticky_q;
    assign nan_cnt_o = nan_cnt_q;

endmodule

// File: doc/fp_classify.md
FP_CLASSIFY -- requirements
Module: fp_classify

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning total float width including the sign bit.
REQ-002 The block SHALL have parameter EXP_W, default 8, meaning exponent width; mantissa width is MAN_W = DATA_W-1-EXP_W and SHALL be at least 2.
REQ-003 The block SHALL have parameter LANES, default 4, meaning operands classified per beat.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning NaN counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port clear_i, input, 1 bit: synchronous clear of sticky flags and NaN counter.
REQ-008 Port valid_i, input, 1 bit: input beat valid.
REQ-009 Port ready_o, output, 1 bit: block accepts a beat this cycle.
REQ-010 Port data_i, input, LANES*DATA_W bits: lane k occupies bits [k*DATA_W +: DATA_W].
REQ-011 Port valid_o, output, 1 bit: output beat valid.
REQ-012 Port ready_i, input, 1 bit: downstream accepts the output beat.
REQ-013 Port class_o, output, LANES*7 bits: lane k at [k*7 +: 7] = {sign, snan, qnan, inf, zero, sub, normal}.
REQ-014 Port sticky_o, output, 4 bits: {nan, inf, zero, sub}, each ORed across all accepted lanes since the last clear.
REQ-015 Port nan_cnt_o, output, CNT_W bits: count of NaN lanes accepted since the last clear, saturating.

Function
REQ-016 A beat SHALL be accepted when valid_i && ready_o; ready_o SHALL equal !valid_o || ready_i.
REQ-017 An accepted beat SHALL appear on class_o with valid_o high on the next cycle: latency exactly 1, throughput 1 beat/cycle under continuous ready_i.
REQ-018 While valid_o && !ready_i, class_o and valid_o SHALL hold stable.
REQ-019 When valid_o && ready_i and no new beat is accepted, valid_o SHALL fall the next cycle.
REQ-020 Per lane: sign SHALL be the MSB; exponent SHALL be the next EXP_W bits; mantissa SHALL be the low MAN_W bits.
REQ-021 qnan SHALL be 1 when the exponent is all ones and the mantissa MSB is 1.
REQ-022 snan SHALL be 1 when the exponent is all ones, the mantissa MSB is 0 and the mantissa is nonzero.
REQ-023 inf SHALL be 1 when the exponent is all ones and the mantissa is zero.
REQ-024 zero SHALL be 1 when the exponent and mantissa are both zero.
REQ-025 sub SHALL be 1 when the exponent is zero and the mantissa is nonzero.
REQ-026 normal SHALL be 1 when the exponent is neither all zeros nor all ones.
REQ-027 Exactly one of {snan, qnan, inf, zero, sub, normal} SHALL be set per lane; sign SHALL be reported for every class, including NaN.
REQ-028 Sticky and counter SHALL update only on accept, using the accepted beat's lanes.
REQ-029 On accept, nan_cnt_o SHALL add the number of lanes with qnan|snan (0..LANES).
REQ-030 nan_cnt_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 When clear_i and an accept occur in the same cycle, state SHALL become exactly the accepted beat's contribution (clear first, then update).
REQ-032 clear_i SHALL NOT affect valid_o, class_o or ready_o.

Reset
REQ-033 While rst is high: valid_o=0, class_o=0, sticky_o=0, nan_cnt_o=0, ready_o=1; any beat in flight SHALL be discarded.
REQ-034 Reset mid-operation SHALL drop a held output beat with no partial sticky or counter update; operation SHALL resume on the first edge after rst falls.

Verification
REQ-035 LANES=4, FP32, ready_i=1, one beat {0x7FC00000, 0x7F800001, 0xFF800000, 0x80000000} -> next cycle valid_o=1; lane classes qnan, snan, inf+sign, zero+sign; sticky_o=4'b1110; nan_cnt_o=2.
REQ-036 Beat {0x00000001, 0x3F800000, 0x807FFFFF, 0x7F7FFFFF} -> sub, normal, sub+sign, normal; sticky sub bit set; nan_cnt_o unchanged.
REQ-037 Hold ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0 after the first beat, class_o stable, second beat accepted only after ready_i=1, no beat lost or duplicated.
REQ-038 CNT_W=3, three beats of four qNaNs -> nan_cnt_o 4, then 7, then 7 (saturated).
REQ-039 clear_i with a concurrent accept of one sNaN -> nan_cnt_o=1, sticky_o=4'b1000; clear_i alone -> all zero.
REQ-040 Assert rst while valid_o=1 and ready_i=0 -> valid_o=0, sticky_o=0 and nan_cnt_o=0 immediately, without waiting for a clock edge.
